// File: rtl/alu_arbiter_if.sv
// Bundle of client-side and ALU-side signals around alu_arbiter.
// slave: the arbiter's view; master: the environment (clients + ALU).
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [2:0]       op0;
  logic [2:0]       op1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             busy;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             alu_e;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ack;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, alu_y, alu_ack,
    output done0, done1, result, err, busy, alu_a, alu_b, alu_op, alu_e
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, alu_y, alu_ack,
    input  done0, done1, result, err, busy, alu_a, alu_b, alu_op, alu_e
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Optional WAIT timeout enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nx;
  logic             ptr_r;
  logic             id_r;
  logic             gnt_s;
  logic             gnt_id_s;
  logic             ack_s;
  logic             tmo_s;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [2:0]       alu_op_r;
  logic             alu_e_r;
  logic [WIDTH-1:0] result_r;
  logic             err_r;
  logic             busy_r;
  logic             done0_r;
  logic             done1_r;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_r;

  // WAIT-phase cycle counter, cleared on the ISSUE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (state_r == ISSUE) begin
      cnt_r <= '0;
    end else if (state_r == WAIT && !bus.alu_ack) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic and grant selection (a lone request ignores the pointer)
  always_comb begin
    state_nx = state_r;
    gnt_s    = 1'b0;
    gnt_id_s = 1'b0;
    ack_s    = 1'b0;
    tmo_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_s    = 1'b1;
          state_nx = ISSUE;
          if (bus.req0 && bus.req1) begin
            gnt_id_s = ptr_r;
          end else begin
            gnt_id_s = bus.req1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (bus.alu_ack) begin
          ack_s    = 1'b1;
          state_nx = DONE;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_r == CNT_MAX) begin
          tmo_s    = 1'b1;
          state_nx = DONE;
        end
`endif
        else begin
          state_nx = WAIT;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs, all derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r    <= 1'b0;
      id_r     <= 1'b0;
      alu_a_r  <= '0;
      alu_b_r  <= '0;
      alu_op_r <= 3'd0;
      alu_e_r  <= 1'b0;
      result_r <= '0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
    end else begin
      if (gnt_s) begin
        id_r     <= gnt_id_s;
        alu_a_r  <= gnt_id_s ? bus.a1  : bus.a0;
        alu_b_r  <= gnt_id_s ? bus.b1  : bus.b0;
        alu_op_r <= gnt_id_s ? bus.op1 : bus.op0;
      end
      if (ack_s) begin
        result_r <= bus.alu_y;
        err_r    <= 1'b0;
      end else if (tmo_s) begin
        result_r <= '0;
        err_r    <= 1'b1;
      end
      if (state_r == DONE) begin
        ptr_r <= ~id_r;
      end
      alu_e_r <= (state_nx == ISSUE) || (state_nx == WAIT);
      busy_r  <= (state_nx != IDLE);
      done0_r <= (state_nx == DONE) && !id_r;
      done1_r <= (state_nx == DONE) && id_r;
    end
  end

  assign bus.alu_a  = alu_a_r;
  assign bus.alu_b  = alu_b_r;
  assign bus.alu_op = alu_op_r;
  assign bus.alu_e  = alu_e_r;
  assign bus.result = result_r;
  assign bus.err    = err_r;
  assign bus.busy   = busy_r;
  assign bus.done0  = done0_r;
  assign bus.done1  = done1_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural ALU whose
// ack arrives a programmable number of enabled cycles after ISSUE.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_miss;
  int   ack_at;
  int   ecnt;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          ack_at;
    logic [31:0] y;
    bit          err;
    int          done_cyc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return ~a;
    endcase
  endfunction

  assign bus.alu_y   = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_ack = bus.alu_e && (ecnt >= ack_at);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counts edges with alu_e high; 1 during the first WAIT cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= bus.alu_e ? ecnt + 1 : 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " done0"},  bus.done0,  1'b0);
    chk({tag, " done1"},  bus.done1,  1'b0);
    chk({tag, " result"}, bus.result, 32'd0);
    chk({tag, " err"},    bus.err,    1'b0);
    chk({tag, " busy"},   bus.busy,   1'b0);
    chk({tag, " alu_e"},  bus.alu_e,  1'b0);
    chk({tag, " alu_a"},  bus.alu_a,  32'd0);
    chk({tag, " alu_b"},  bus.alu_b,  32'd0);
    chk({tag, " alu_op"}, bus.alu_op, 3'd0);
  endtask

  // Called just after a negedge with the DUT idle; the next posedge is edge 0.
  task automatic run_vec(input vec_t v, input string tag);
    int   seen;
    logic stable;
    ack_at = v.ack_at;
    if (v.id) begin
      bus.req1 = 1'b1; bus.a1 = v.a; bus.b1 = v.b; bus.op1 = v.op;
    end else begin
      bus.req0 = 1'b1; bus.a0 = v.a; bus.b0 = v.b; bus.op0 = v.op;
    end
    seen   = 0;
    stable = 1'b1;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.a0 = $urandom; bus.b0 = $urandom; bus.op0 = 3'($urandom);
        bus.a1 = $urandom; bus.b1 = $urandom; bus.op1 = 3'($urandom);
      end
      if (bus.done0 || bus.done1) begin
        seen = c;
      end else if (!(bus.alu_e === 1'b1 && bus.busy === 1'b1 && bus.alu_a === v.a &&
                     bus.alu_b === v.b && bus.alu_op === v.op)) begin
        stable = 1'b0;
      end
    end
    chk({tag, " done_cycle"}, seen, v.done_cyc);
    chk({tag, " operands_held"}, stable, 1'b1);
    chk({tag, " done_id"}, {bus.done1, bus.done0}, v.id ? 2'b10 : 2'b01);
    chk({tag, " result"}, bus.result, v.y);
    chk({tag, " err"}, bus.err, v.err);
    chk({tag, " alu_e_done"}, bus.alu_e, 1'b0);
    chk({tag, " busy_done"}, bus.busy, 1'b1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    chk({tag, " idle_done"}, {bus.done1, bus.done0}, 2'b00);
    chk({tag, " idle_busy"}, bus.busy, 1'b0);
    chk({tag, " result_hold"}, bus.result, v.y);
  endtask

  initial begin
    vec_t v;
    n_cmp  = 0;
    n_miss = 0;
    ack_at = 1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = 32'd0; bus.b0 = 32'd0; bus.op0 = 3'd0;
    bus.a1 = 32'd0; bus.b1 = 32'd0; bus.op1 = 3'd0;
    rst_n = 1'b0;

    //        id  a             b             op    ack  y             err done
    tbl.push_back('{1'b0, 32'd8, 32'd6, 3'd0, 1, 32'h0000000E, 1'b0, 3});
    tbl.push_back('{1'b0, 32'd8, 32'd6, 3'd1, 1, 32'h00000002, 1'b0, 3});
    tbl.push_back('{1'b0, 32'd8, 32'd6, 3'd2, 1, 32'h00000000, 1'b0, 3});
    tbl.push_back('{1'b0, 32'd8, 32'd6, 3'd3, 1, 32'h0000000E, 1'b0, 3});
    tbl.push_back('{1'b0, 32'd8, 32'd6, 3'd4, 1, 32'h0000000E, 1'b0, 3});
    tbl.push_back('{1'b0, 32'd8, 32'd6, 3'd5, 1, 32'h00000200, 1'b0, 3});
    tbl.push_back('{1'b0, 32'd8, 32'd6, 3'd6, 1, 32'h00000000, 1'b0, 3});
    tbl.push_back('{1'b0, 32'd8, 32'd6, 3'd7, 1, 32'hFFFFFFF7, 1'b0, 3});
    tbl.push_back('{1'b1, 32'hF0F01234, 32'h0FF000FF, 3'd0, 0, 32'h00E01333, 1'b0, 3});
    tbl.push_back('{1'b1, 32'hF0F01234, 32'h0FF000FF, 3'd4, 5, 32'hFF0012CB, 1'b0, 7});
    tbl.push_back('{1'b0, 32'hF0F01234, 32'h0FF000FF, 3'd2, 2, 32'h00F00034, 1'b0, 4});
`ifdef ALU_ARB_TIMEOUT_EN
    tbl.push_back('{1'b0, 32'd3, 32'd4, 3'd0, 1000, 32'h00000000, 1'b1, 17});
`endif
    tbl.push_back('{1'b1, 32'd3, 32'd4, 3'd1, 1, 32'hFFFFFFFF, 1'b0, 3});

    // reset with random activity on the inputs
    repeat (3) begin
      @(negedge clk);
      bus.req0 = 1'($urandom); bus.req1 = 1'($urandom);
      bus.a0 = $urandom; bus.b0 = $urandom; bus.a1 = $urandom; bus.b1 = $urandom;
      chk_zero("reset");
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("post_reset");

    foreach (tbl[i]) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // contention: both requests held from reset release
    rst_n = 1'b0;
    ack_at = 1;
    bus.req0 = 1'b1; bus.a0 = 32'h11111111; bus.b0 = 32'd1; bus.op0 = 3'd0;
    bus.req1 = 1'b1; bus.a1 = 32'h22222222; bus.b1 = 32'd2; bus.op1 = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c % 4 == 1) begin
        chk($sformatf("rr alu_a c%0d", c), bus.alu_a,
            (c == 1 || c == 9) ? 32'h11111111 : 32'h22222222);
      end
      chk($sformatf("rr done0 c%0d", c), bus.done0, (c == 3 || c == 11) ? 1'b1 : 1'b0);
      chk($sformatf("rr done1 c%0d", c), bus.done1, (c == 7 || c == 15) ? 1'b1 : 1'b0);
    end
    chk("rr result", bus.result, 32'h22222224);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);

    // reset pulled during the second WAIT cycle
    ack_at = 1000;
    bus.req0 = 1'b1; bus.a0 = 32'd5; bus.b0 = 32'd7; bus.op0 = 3'd0;
    repeat (3) @(negedge clk);
    chk("rw alu_e_before", bus.alu_e, 1'b1);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1;
    chk_zero("rw reset");
    repeat (2) begin
      @(negedge clk);
      chk("rw no_done", {bus.done1, bus.done0}, 2'b00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    v = '{1'b1, 32'd9, 32'd4, 3'd1, 1, 32'h00000005, 1'b0, 3};
    run_vec(v, "rw after");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 32-bit ALU between two requesters.
- Grants the ALU to one requester at a time and registers that requester's operands and opcode.
- Drives the ALU's `a`/`b`/`opcode`/`e` inputs and waits for `ack`.
- Returns `y` to the granted requester with a one-cycle done pulse.
- Sits between the two client datapaths and the combinational ALU.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `TIMEOUT`, 15, max WAIT cycles before error (used only with the timeout feature)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req0` / `req1`  in  1  request from requester 0 / 1
- `a0`, `b0` / `a1`, `b1`  in  WIDTH  operands for requester 0 / 1
- `op0` / `op1`  in  3  ALU opcode for requester 0 / 1
- `done0` / `done1`  out  1  one-cycle completion pulse to requester 0 / 1
- `result`  out  WIDTH  registered ALU result of the last completed operation
- `err`  out  1  last completed operation timed out
- `busy`  out  1  high in any state other than IDLE
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU
- `alu_op`  out  3  registered opcode to the ALU
- `alu_e`  out  1  ALU enable
- `alu_y`  in  WIDTH  ALU result
- `alu_ack`  in  1  ALU acknowledge

## Operation
- **State machine**: IDLE → ISSUE → WAIT → DONE → IDLE.
- **IDLE**
  - `alu_e` = 0.
  - If any `reqN` is high at the rising edge: grant one requester, capture its `aN`/`bN`/`opN` into `alu_a`/`alu_b`/`alu_op`, record its id, go to ISSUE.
  - If only one request is high, grant it regardless of the priority pointer.
  - If both are high, grant the requester named by the priority pointer.
- **ISSUE**
  - `alu_e` = 1 with the captured operands held stable.
  - `alu_ack` is ignored in this state.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - `alu_e` = 1.
  - If `alu_ack` = 1 at the edge: `result` ← `alu_y`, `err` ← 0, go to DONE.
- **DONE**
  - `doneN` of the granted id = 1 for exactly this cycle; `alu_e` = 0.
  - Priority pointer ← the other requester. Go to IDLE.
- **Operand hold**: operands need not be held after the grant edge; they are registered.
- **Request rule**: `reqN` must stay high until `doneN`.
  - `reqN` is not sampled during DONE.
  - `reqN` still high in the following IDLE cycle is treated as a new request.
- **Outputs between operations**: `result` and `err` hold their values until the next DONE.
- **Alternation**: with both requests held continuously, grants alternate 0,1,0,1.

## Timing
- **Reset**: asynchronous, applies immediately on `rst_n` low.
  - State = IDLE, pointer = requester 0.
  - `done0`, `done1`, `err`, `busy`, `alu_e` = 0.
  - `result`, `alu_a`, `alu_b`, `alu_op` = 0.
- **Reset mid-operation**: aborts the operation; no `doneN` is issued. Operation after release is identical to post-reset.
- **Latency** (request sampled at edge 0 in IDLE):
  - ISSUE in cycle 1, WAIT from cycle 2.
  - With `alu_ack` high at the first WAIT edge, `doneN` is high in cycle 3.
  - Each additional WAIT cycle adds 1.
- **Throughput**: back-to-back issue period is 4 cycles (DONE → IDLE → ISSUE → WAIT → DONE).
- **`busy`**: = 1 from the ISSUE cycle through the DONE cycle inclusive.

## Configuration
- Macro: `ALU_ARB_TIMEOUT_EN`.
- **Defined**:
  - A counter of width ceil(log2(TIMEOUT)) increments on each WAIT edge without `alu_ack`.
  - At counter == TIMEOUT−1 with no ack: `result` ← 0, `err` ← 1, go to DONE.
  - The WAIT phase therefore lasts at most TIMEOUT cycles.
  - `alu_ack` arriving on that final edge takes priority: normal completion, `err` = 0.
- **Undefined**:
  - No counter; WAIT lasts until `alu_ack`, indefinitely if necessary.
  - `err` is constant 0.

## Test plan
- **Reset**: assert `rst_n` = 0 with random inputs → all outputs 0, `busy` = 0. After release with no requests → outputs remain 0.
- **Single request**: `req0` = 1, `a0` = 8, `b0` = 6, `op0` = 000; bench ALU model returns `alu_ack` = 1, `alu_y` = 32'h0000000E from the first WAIT cycle.
  - Required: `alu_a` = 8, `alu_b` = 6, `alu_op` = 000.
  - `done0` pulse in cycle 3; `result` = 32'h0000000E; `err` = 0.
  - Repeat for opcodes 001–111.
- **Contention**: `req0` and `req1` held high from reset release, with distinct operands → `done0`, `done1`, `done0`, `done1`… at 4-cycle spacing. The first grant goes to requester 0, and each `alu_a` matches the granted requester.
- **Delayed ack**: `alu_ack` delayed 5 cycles after ISSUE → `doneN` in cycle 7. `alu_e` stays 1 throughout WAIT, and `alu_a`/`alu_b`/`alu_op` are stable.
- **Timeout** (with `ALU_ARB_TIMEOUT_EN`, `TIMEOUT` = 15): `alu_ack` tied 0 → `done0` in cycle 17, `err` = 1, `result` = 0. A following request with a working ack clears `err` to 0.
- **Reset in WAIT**: pull `rst_n` low in the second WAIT cycle → no `doneN`, outputs return to 0. After release, `req1` alone is served with `done1` in cycle 3.
